// File: rtl/dds_gen_pkg.sv
// Shared constants and types for the DDS generator and its frequency-meter benches.
package dds_gen_pkg;

    localparam int unsigned CLK_10M_HZ   = 10_000_000;
    localparam int unsigned DDS_F_MAX    = 5_000_000;
    localparam int unsigned DDS_K_TW     = 439_805;      // round(2^42 / 10e6)
    localparam logic [9:0]  DDS_MIDSCALE = 10'd512;

    // pi scaled by 2^30, used by the elaboration-time sine table builder
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_MUL,
        LD_WRITE
    } load_state_e;

    // round(511.5 + 511.5*sin(2*pi*k/1024)) in fixed point: quarter-wave folding
    // plus an odd Taylor series to x^17 in Q30, then floor((1024 +/- 1023*s)/2).
    function automatic logic [9:0] sine_code(input int unsigned k);
        longint      x;
        longint      x2;
        longint      term;
        longint      sum;
        longint      num;
        int unsigned j;
        j = k % 512;
        if (j > 256) begin
            j = 512 - j;
        end
        x    = (PI_Q30 * longint'(j) + 64'sd256) / 64'sd512;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int unsigned n = 1; n <= 8; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        if (k >= 512) begin
            num = (64'sd1024 <<< 30) - 64'sd1023 * sum;
        end else begin
            num = (64'sd1024 <<< 30) + 64'sd1023 * sum;
        end
        num = num >>> 31;
        if (num > 64'sd1023) begin
            num = 64'sd1023;
        end
        if (num < 64'sd0) begin
            num = 64'sd0;
        end
        return num[9:0];
    endfunction

endpackage

// File: rtl/dds_gen_if.sv
// Frequency-load handshake and waveform output bundle of the DDS generator.
interface dds_gen_if;

    logic [31:0] freq_set;
    logic        freq_load;
    logic        ready;
    logic        freq_err;
    logic [1:0]  wave_sel;
    logic        out_en;
    logic [9:0]  dac_data;
    logic        sync_out;

    modport master (
        output freq_set, freq_load, wave_sel, out_en,
        input  ready, freq_err, dac_data, sync_out
    );

    modport slave (
        input  freq_set, freq_load, wave_sel, out_en,
        output ready, freq_err, dac_data, sync_out
    );

endinterface

// File: rtl/dds_gen_sine_lut.sv
// 1024 x 10 sine ROM, offset binary, one cycle of read latency.
module sine_lut
    import dds_gen_pkg::*;
(
    input  logic       clk_10m,
    input  logic       rst,
    input  logic [9:0] addr,
    output logic [9:0] data
);

    logic [9:0] rom [1024];

    for (genvar k = 0; k < 1024; k++) begin : g_rom
        localparam logic [9:0] ENTRY = sine_code(k);
        assign rom[k] = ENTRY;
    end

    // registered ROM read
    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/dds_gen.sv
// Direct digital synthesiser: Hz request -> tuning word -> 32-bit phase
// accumulator -> sine/square/triangle/sawtooth DAC code with 2-cycle latency.
module dds_gen
    import dds_gen_pkg::*;
#(
    parameter int unsigned F_MAX    = DDS_F_MAX,
    parameter int unsigned K_TW     = DDS_K_TW,
    parameter logic [9:0]  MIDSCALE = DDS_MIDSCALE
) (
    input  logic     clk_10m,
    input  logic     rst,
    output logic     clk_dac,
    dds_gen_if.slave bus
);

    load_state_e state;
    load_state_e state_nxt;
    logic        ready_c;
    logic        accept;
    logic        prod_en;
    logic        tw_en;

    logic [22:0] f_reg;
    logic        freq_err;
    logic [41:0] prod;
    logic [31:0] tuning_word;
    logic [31:0] acc;
    logic        carry;

    logic [9:0]  sine_q;
    logic [9:0]  alt_c;
    logic [9:0]  alt_q;
    wave_e       sel1;
    logic        en1;
    logic        carry1;
    logic [9:0]  dac_q;
    logic        sync_q;
    logic        prod_unused;

    assign clk_dac      = clk_10m;
    assign bus.ready    = ready_c;
    assign bus.freq_err = freq_err;
    assign bus.dac_data = dac_q;
    assign bus.sync_out = sync_q;
    assign prod_unused  = ^prod[9:0];

    // load sequencer state register
    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // load sequencer: sample, multiply, write tuning word
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        prod_en   = 1'b0;
        tw_en     = 1'b0;
        case (state)
            LD_IDLE: begin
                ready_c = 1'b1;
                if (bus.freq_load) begin
                    state_nxt = LD_MUL;
                end
            end
            LD_MUL: begin
                prod_en   = 1'b1;
                state_nxt = LD_WRITE;
            end
            LD_WRITE: begin
                tw_en     = 1'b1;
                state_nxt = LD_IDLE;
            end
            default: state_nxt = LD_IDLE;
        endcase
        accept = ready_c & bus.freq_load;
    end

    // capture request with clamping; error flag follows the latest accepted load
    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            f_reg    <= '0;
            freq_err <= 1'b0;
        end else if (accept) begin
            if (bus.freq_set > F_MAX) begin
                f_reg    <= 23'(F_MAX);
                freq_err <= 1'b1;
            end else begin
                f_reg    <= 23'(bus.freq_set);
                freq_err <= 1'b0;
            end
        end
    end

    // Hz-to-tuning-word product and tuning word register
    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            prod        <= '0;
            tuning_word <= '0;
        end else begin
            if (prod_en) begin
                prod <= 42'(f_reg) * 42'(K_TW);
            end
            if (tw_en) begin
                tuning_word <= prod[41:10];
            end
        end
    end

    // phase accumulator with registered carry-out marking each wrap
    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
        end else begin
            {carry, acc} <= {1'b0, acc} + {1'b0, tuning_word};
        end
    end

    sine_lut u_sine_lut (
        .clk_10m (clk_10m),
        .rst     (rst),
        .addr    (acc[31:22]),
        .data    (sine_q)
    );

    // non-sine waveform shapes from the current phase
    always_comb begin
        alt_c = acc[31:22];
        case (wave_e'(bus.wave_sel))
            WAVE_SQUARE: alt_c = acc[31] ? '0 : '1;
            WAVE_TRI:    alt_c = acc[31] ? ~{acc[30:22], 1'b0} : {acc[30:22], 1'b0};
            WAVE_SAW:    alt_c = acc[31:22];
            default:     alt_c = acc[31:22];
        endcase
    end

    // stage 1: shapes, select, enable and carry aligned with the ROM read
    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            alt_q  <= '0;
            sel1   <= WAVE_SINE;
            en1    <= 1'b0;
            carry1 <= 1'b0;
        end else begin
            alt_q  <= alt_c;
            sel1   <= wave_e'(bus.wave_sel);
            en1    <= bus.out_en;
            carry1 <= carry;
        end
    end

    // stage 2: output mux, mute to midscale, period marker
    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            dac_q  <= MIDSCALE;
            sync_q <= 1'b0;
        end else begin
            if (!en1) begin
                dac_q <= MIDSCALE;
            end else if (sel1 == WAVE_SINE) begin
                dac_q <= sine_q;
            end else begin
                dac_q <= alt_q;
            end
            sync_q <= carry1;
        end
    end

endmodule

// File: tb/tb_dds_gen.sv
// Bench for dds_gen: vector table of loads, directed corner sequences and
// random stimulus against a behavioural phase/waveform model.
module tb_dds_gen;
    import dds_gen_pkg::*;

    localparam int HALF = int'(500_000_000 / CLK_10M_HZ);

    typedef struct {
        logic [31:0] freq;
        longint      tw;
        logic        err;
    } load_vec_t;

    logic clk_10m = 1'b0;
    logic rst;
    logic clk_dac;

    dds_gen_if bus ();

    dds_gen #(
        .F_MAX    (DDS_F_MAX),
        .K_TW     (DDS_K_TW),
        .MIDSCALE (DDS_MIDSCALE)
    ) dut (
        .clk_10m (clk_10m),
        .rst     (rst),
        .clk_dac (clk_dac),
        .bus     (bus)
    );

    always #(HALF) clk_10m = ~clk_10m;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    longint unsigned m_acc;
    logic            m_carry;
    longint unsigned m_tw;
    logic            pend_act;
    int              pend_left;
    longint unsigned pend_tw;
    logic            m_err;
    int              exp_dac;
    int              pipe_dac;
    logic            exp_sync;
    logic            pipe_sync;
    longint unsigned m_sum;
    longint unsigned m_f;
    logic            m_rdy;

    function automatic int sine_ref(input int p);
        real v;
        v = 511.5 + 511.5 * $sin(2.0 * 3.14159265358979 * real'(p) / 1024.0);
        return $rtoi(v + 0.5);
    endfunction

    function automatic int wave_of(input longint unsigned a, input logic [1:0] sel);
        int p;
        int t;
        p = int'(a >> 22);
        t = p % 512;
        case (sel)
            2'd0:    return sine_ref(p);
            2'd1:    return (a < 64'h8000_0000) ? 1023 : 0;
            2'd2:    return (a < 64'h8000_0000) ? 2 * t : 1023 - 2 * t;
            default: return p;
        endcase
    endfunction

    // behavioural model: the DAC shows the phase from two clocks back
    always @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            m_acc     = 0;
            m_carry   = 1'b0;
            m_tw      = 0;
            pend_act  = 1'b0;
            pend_left = 0;
            pend_tw   = 0;
            m_err     = 1'b0;
            exp_dac   = 512;
            pipe_dac  = 512;
            exp_sync  = 1'b0;
            pipe_sync = 1'b0;
        end else begin
            m_rdy     = !pend_act;
            exp_dac   = pipe_dac;
            exp_sync  = pipe_sync;
            pipe_dac  = bus.out_en ? wave_of(m_acc, bus.wave_sel) : 512;
            pipe_sync = m_carry;
            m_sum     = m_acc + m_tw;
            m_carry   = (m_sum >> 32) != 0;
            m_acc     = m_sum & 64'hFFFF_FFFF;
            if (pend_act) begin
                pend_left = pend_left - 1;
                if (pend_left == 0) begin
                    m_tw     = pend_tw;
                    pend_act = 1'b0;
                end
            end
            if (m_rdy && bus.freq_load) begin
                m_f   = 64'(bus.freq_set);
                m_err = m_f > 64'd5_000_000;
                if (m_err) m_f = 64'd5_000_000;
                pend_tw   = (m_f * 64'd439_805) >> 10;
                pend_act  = 1'b1;
                pend_left = 2;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // advance one clock and compare every observable against the model
    task automatic step();
        @(negedge clk_10m);
        check("m_dac",   64'(bus.dac_data),    64'(exp_dac));
        check("m_sync",  64'(bus.sync_out),    64'(exp_sync));
        check("m_ready", 64'(bus.ready),       64'(!pend_act));
        check("m_err",   64'(bus.freq_err),    64'(m_err));
        check("m_tw",    64'(dut.tuning_word), 64'(m_tw));
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!bus.ready && guard < 10) begin
            step();
            guard++;
        end
        check("ready_wait", 64'(bus.ready), 64'd1);
    endtask

    task automatic do_load(input logic [31:0] f);
        wait_ready();
        bus.freq_set  = f;
        bus.freq_load = 1'b1;
        step();
        bus.freq_load = 1'b0;
    endtask

    initial begin
        load_vec_t vecs [9];
        int cnt_sync;
        int cnt_hi;
        int cnt_other;
        int period;
        int dmin;
        int dmax;
        int guard;

        vecs[0] = '{32'd1000,         64'd429497,     1'b0};
        vecs[1] = '{32'd0,            64'd0,          1'b0};
        vecs[2] = '{32'd6000000,      64'd2147485351, 1'b1};
        vecs[3] = '{32'd100,          64'd42949,      1'b0};
        vecs[4] = '{32'd5000000,      64'd2147485351, 1'b0};
        vecs[5] = '{32'd5000001,      64'd2147485351, 1'b1};
        vecs[6] = '{32'd1,            64'd429,        1'b0};
        vecs[7] = '{32'hFFFF_FFFF,    64'd2147485351, 1'b1};
        vecs[8] = '{32'd2000000,      64'd858994140,  1'b0};

        rst           = 1'b1;
        bus.freq_set  = '0;
        bus.freq_load = 1'b0;
        bus.wave_sel  = 2'd0;
        bus.out_en    = 1'b1;
        repeat (3) step();
        check("rst_dac",   64'(bus.dac_data),    64'd512);
        check("rst_sync",  64'(bus.sync_out),    64'd0);
        check("rst_ready", 64'(bus.ready),       64'd1);
        check("rst_err",   64'(bus.freq_err),    64'd0);
        check("rst_tw",    64'(dut.tuning_word), 64'd0);
        check("rst_acc",   64'(dut.acc),         64'd0);
        rst = 1'b0;

        for (int c = 0; c < 50; c++) begin
            step();
            check("idle_dac",  64'(bus.dac_data), 64'd512);
            check("idle_sync", 64'(bus.sync_out), 64'd0);
        end
        @(posedge clk_10m);
        #1;
        check("clk_dac_hi", 64'(clk_dac), 64'd1);
        step();
        check("clk_dac_lo", 64'(clk_dac), 64'd0);

        foreach (vecs[i]) begin
            do_load(vecs[i].freq);
            repeat (2) step();
            check($sformatf("tbl%0d_tw", i),    64'(dut.tuning_word), vecs[i].tw);
            check($sformatf("tbl%0d_err", i),   64'(bus.freq_err),    64'(vecs[i].err));
            check($sformatf("tbl%0d_ready", i), 64'(bus.ready),       64'd1);
        end

        // 1 kHz sine: one full period between sync pulses, full code span
        bus.wave_sel = 2'd0;
        do_load(32'd1000);
        repeat (3) step();
        guard = 0;
        while (!bus.sync_out && guard < 20000) begin
            step();
            guard++;
        end
        check("sine_first_sync", 64'(bus.sync_out), 64'd1);
        period = 0;
        dmin   = 1023;
        dmax   = 0;
        do begin
            step();
            period++;
            if (int'(bus.dac_data) < dmin) dmin = int'(bus.dac_data);
            if (int'(bus.dac_data) > dmax) dmax = int'(bus.dac_data);
        end while (!bus.sync_out && period < 20000);
        check_range("sine_period", period, 9999, 10001);
        check("sine_min", 64'(dmin), 64'd0);
        check("sine_max", 64'(dmax), 64'd1023);

        // 2 MHz square, then muted: sync cadence must not change
        bus.wave_sel = 2'd1;
        do_load(32'd2000000);
        repeat (4) step();
        cnt_sync  = 0;
        cnt_hi    = 0;
        cnt_other = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (bus.sync_out) cnt_sync++;
            if (bus.dac_data == 10'd1023) cnt_hi++;
            else if (bus.dac_data != 10'd0) cnt_other++;
        end
        check_range("sq_syncs", cnt_sync, 199, 201);
        check_range("sq_high", cnt_hi, 390, 610);
        check("sq_levels", 64'(cnt_other), 64'd0);

        bus.out_en = 1'b0;
        repeat (2) step();
        check("mute_dac", 64'(bus.dac_data), 64'd512);
        cnt_sync = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (bus.sync_out) cnt_sync++;
            if (c % 100 == 0) check("mute_hold", 64'(bus.dac_data), 64'd512);
        end
        check_range("mute_syncs", cnt_sync, 199, 201);
        bus.out_en = 1'b1;

        // strobe held two cycles: second value ignored
        bus.wave_sel = 2'd2;
        wait_ready();
        bus.freq_set  = 32'd2000;
        bus.freq_load = 1'b1;
        step();
        bus.freq_set  = 32'd6000000;
        step();
        bus.freq_load = 1'b0;
        step();
        check("dbl_tw",  64'(dut.tuning_word), 64'd858994);
        check("dbl_err", 64'(bus.freq_err),    64'd0);

        // reset during a pending load aborts it; first clock after reset loads
        wait_ready();
        bus.freq_set  = 32'd3000000;
        bus.freq_load = 1'b1;
        step();
        bus.freq_load = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("abort_ready", 64'(bus.ready),       64'd1);
        check("abort_tw",    64'(dut.tuning_word), 64'd0);
        check("abort_dac",   64'(bus.dac_data),    64'd512);
        check("abort_sync",  64'(bus.sync_out),    64'd0);
        repeat (2) step();
        rst           = 1'b0;
        bus.freq_set  = 32'd1000;
        bus.freq_load = 1'b1;
        step();
        bus.freq_load = 1'b0;
        check("post_rst_busy", 64'(bus.ready),       64'd0);
        check("post_rst_tw0",  64'(dut.tuning_word), 64'd0);
        step();
        check("post_rst_tw1",  64'(dut.tuning_word), 64'd0);
        step();
        check("post_rst_tw2",  64'(dut.tuning_word), 64'd429497);

        // random waveform, enable and load traffic
        for (int c = 0; c < 4000; c++) begin
            bus.wave_sel = 2'($urandom_range(0, 3));
            bus.out_en   = ($urandom_range(0, 7) != 0);
            if (bus.ready && $urandom_range(0, 15) == 0) begin
                bus.freq_load = 1'b1;
                bus.freq_set  = ($urandom_range(0, 3) == 0) ? $urandom()
                                                            : 32'($urandom_range(0, 6_000_000));
            end else begin
                bus.freq_load = ($urandom_range(0, 31) == 0);
                bus.freq_set  = $urandom();
            end
            step();
        end
        bus.freq_load = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
